bc_mac_drain: RTL and testbench

//  Read-out controller for one row of chained BC-MAC slices. Drains the accumulated partial sum
//  out of the sumout shift chain, one bit per cycle, LSB first.

---
 rtl/bc_mac_pkg.sv | 11 +
 rtl/bc_mac_drain_round_sat.sv | 22 ++
 rtl/bc_mac_drain.sv | 63 ++++++
 tb/tb_bc_mac_drain.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bc_mac_pkg.sv
// bc_mac_pkg: shared BC-MAC row geometry and drain FSM state encoding
package bc_mac_pkg;
  localparam int SEG_W = 4;
  localparam int NUM_SEG = 4;
  localparam int OUT_W = SEG_W * NUM_SEG;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/bc_mac_drain_round_sat.sv
// bc_round_sat: unsigned truncate, optional round-half-up, saturate on carry-out
module bc_round_sat #(
  parameter int OUT_W = 16,
  parameter int TRUNC = 0,
  parameter int RND = 0,
  localparam int RES_W = OUT_W - TRUNC
) (
  input  logic [OUT_W-1:0] w,
  output logic [RES_W-1:0] res
);
  logic rbit;
  logic [RES_W:0] sum;
  generate
    if (RND != 0 && TRUNC > 0) begin : g_rnd
      assign rbit = w[TRUNC-1];
    end else begin : g_nornd
      assign rbit = 1'b0;
    end
  endgenerate
  assign sum = {1'b0, w[OUT_W-1:TRUNC]} + {{RES_W{1'b0}}, rbit};
  assign res = sum[RES_W] ? '1 : sum[RES_W-1:0];
endmodule

// File: rtl/bc_mac_drain.sv
// bc_mac_drain: drains a BC-MAC row's sumout chain LSB-first and presents one post-processed word per drain
module bc_mac_drain #(
  parameter int SEG_W = bc_mac_pkg::SEG_W,
  parameter int NUM_SEG = bc_mac_pkg::NUM_SEG,
  parameter int TRUNC = 0,
  parameter int RND = 0,
  localparam int OUT_W = SEG_W * NUM_SEG,
  localparam int RES_W = OUT_W - TRUNC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ser_in,
  output logic             sft_en,
  output logic             sft_in,
  output logic             act_gate,
  output logic             busy,
  output logic [RES_W-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready
);
  import bc_mac_pkg::*;
  localparam int CW = $clog2(OUT_W);
  state_t state;
  logic [CW-1:0] cnt;
  logic [OUT_W-1:0] cap, nxt;
  logic [RES_W-1:0] f_res;
  assign nxt = {ser_in, cap[OUT_W-1:1]};
  bc_round_sat #(.OUT_W(OUT_W), .TRUNC(TRUNC), .RND(RND)) u_rs (.w(nxt), .res(f_res));
  assign sft_en = state == ST_DRAIN;
  assign act_gate = state == ST_DRAIN;
  assign busy = state == ST_DRAIN;
  assign res_valid = state == ST_HOLD;
  assign sft_in = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      cap <= '0;
      res_data <= '0;
    end else
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_DRAIN;
          cnt <= '0;
        end
        ST_DRAIN: if (abort) state <= ST_IDLE;
        else begin
          cap <= nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(OUT_W - 1)) begin
            state <= ST_HOLD;
            res_data <= f_res;
          end
        end
        ST_HOLD: if (res_ready) begin
          state <= start ? ST_DRAIN : ST_IDLE;
          cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_bc_mac_drain.sv
// tb_bc_mac_drain: scoreboard bench; plain and TRUNC=4/RND=1 instances share one modelled chain
module tb_bc_mac_drain;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, res_ready = 1;
  logic sft_en, sft_in, act_gate, busy, res_valid;
  logic sft_en2, sft_in2, act_gate2, busy2, res_valid2;
  logic [15:0] res_data, chain = 16'h0, load_val = 16'h0;
  logic [11:0] res_data2;
  logic load = 0;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] q1[$];
  logic [11:0] q2[$];

  always #5 clk = ~clk;

  bc_mac_drain u1 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ser_in(chain[0]),
    .sft_en(sft_en), .sft_in(sft_in), .act_gate(act_gate), .busy(busy), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready));
  bc_mac_drain #(.TRUNC(4), .RND(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ser_in(chain[0]), .sft_en(sft_en2), .sft_in(sft_in2), .act_gate(act_gate2), .busy(busy2),
    .res_data(res_data2), .res_valid(res_valid2), .res_ready(res_ready));

  always @(posedge clk)
    if (load) chain <= load_val;
    else if (sft_en) chain <= {sft_in, chain[15:1]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && res_valid && res_ready) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL res1_unexpected act=%0h req=none", res_data);
      end else check("res1", res_data, q1.pop_front());
    end

  always @(negedge clk)
    if (rst_n && res_valid2 && res_ready) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL res2_unexpected act=%0h req=none", res_data2);
      end else check("res2", res_data2, q2.pop_front());
    end

  task automatic load_chain(input logic [15:0] w);
    load_val = w;
    load = 1;
    @(posedge clk);
    #1 load = 0;
  endtask

  task automatic expect_res(input logic [15:0] e1, input logic [11:0] e2);
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic drain();
    int n = 0, cyc = 0;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int i = 1; i <= 40 && cyc == 0; i++) begin
      @(negedge clk);
      if (sft_en) n++;
      if (res_valid) cyc = i;
    end
    check("sft_len", n, 16);
    check("valid_cyc", cyc, 17);
  endtask

  initial begin
    logic seen;
    int found;
    #2;
    check("rst_sft_en", sft_en, 0);
    check("rst_act_gate", act_gate, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_sft_in", sft_in, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    // basic drain
    load_chain(16'hA5C3);
    expect_res(16'hA5C3, 12'hA5C);
    drain();
    @(posedge clk);
    #1 check("chain_cleared", chain, 16'h0000);
    // backpressure with start re-pulsed during HOLD
    res_ready = 0;
    load_chain(16'hA5C3);
    expect_res(16'hA5C3, 12'hA5C);
    drain();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 start = (i == 2);
      @(negedge clk);
      check("hold_data", res_data, 16'hA5C3);
      check("hold_valid", res_valid, 1);
      check("hold_busy", busy, 0);
    end
    @(posedge clk);
    #1 res_ready = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_hold_busy", busy, 0);
      check("post_hold_valid", res_valid, 0);
    end
    // back-to-back
    res_ready = 0;
    load_chain(16'hA5C3);
    expect_res(16'hA5C3, 12'hA5C);
    drain();
    load_chain(16'h1234);
    expect_res(16'h1234, 12'h123);
    @(posedge clk);
    #1 res_ready = 1;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    check("b2b_sft_en", sft_en, 1);
    check("b2b_busy", busy, 1);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (res_valid) found = 1;
    end
    check("b2b_valid_seen", found, 1);
    // abort during DRAIN, then a clean drain
    load_chain(16'h5A5A);
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #1 abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    check("abort_sft_en", sft_en, 0);
    check("abort_busy", busy, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= res_valid | res_valid2;
    end
    check("abort_no_valid", seen, 0);
    load_chain(16'h00F1);
    expect_res(16'h00F1, 12'h00F);
    drain();
    // round / saturate (seen on the TRUNC=4 RND=1 instance)
    load_chain(16'h0128);
    expect_res(16'h0128, 12'h013);
    drain();
    load_chain(16'hFFF8);
    expect_res(16'hFFF8, 12'hFFF);
    drain();
    load_chain(16'h0127);
    expect_res(16'h0127, 12'h012);
    drain();
    // async reset mid-drain
    load_chain(16'hBEEF);
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (7) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("mid_rst_sft_en", sft_en, 0);
    check("mid_rst_act_gate", act_gate, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_data", res_data, 0);
    check("mid_rst_data2", res_data2, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_sft_en", sft_en, 0);
    load_chain(16'h3C5A);
    expect_res(16'h3C5A, 12'h3C6);
    drain();
    repeat (3) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1);
  end
endmodule
